// File: rtl/dac_sample_pacer.sv
// dac_sample_pacer: output pacing stage of the AXI DAC peripheral.
// Buffers 8-bit samples from the register/DMA front end in a small FIFO and
// plays them out on the dac_clk/dac_data pins at the REG_CLK_DIV rate.
//
// Ports:
//   aclk, areset       system clock, synchronous active-high reset
//   enable             pacing enable
//   flush              one-cycle pulse, empties the FIFO
//   clk_div            period minus one in aclk cycles (0 treated as 1)
//   underrun_clr       one-cycle pulse, clears the sticky underrun flag
//   s_data/s_valid     input sample stream
//   s_ready            FIFO not full (combinational)
//   dac_clk, dac_data  DAC pins, data latched by the DAC on dac_clk rise
//   fifo_level         current FIFO occupancy
//   underrun           sticky, a tick found the FIFO empty
//   busy               enable high or FIFO non-empty (combinational)
module dac_sample_pacer #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned DIV_W      = 16
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic                          enable,
   input  logic                          flush,
   input  logic [DIV_W-1:0]              clk_div,
   input  logic                          underrun_clr,
   input  logic [DATA_W-1:0]             s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic                          dac_clk,
   output logic [DATA_W-1:0]             dac_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underrun,
   output logic                          busy
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   // One extra bit so the largest period (2**DIV_W) is representable.
   localparam int unsigned CNT_W = DIV_W + 1;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [CNT_W-1:0]  phase_q, phase_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic              dac_clk_q, dac_clk_d;
   logic [DATA_W-1:0] dac_data_q, dac_data_d;
   logic              underrun_q, underrun_d;

   logic              empty;
   logic              tick;
   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  period_new;
   logic [CNT_W-1:0]  half;

   // State register
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         phase_q    <= '0;
         period_q   <= CNT_W'(2);
         dac_clk_q  <= 1'b0;
         dac_data_q <= '0;
         underrun_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         phase_q    <= phase_d;
         period_q   <= period_d;
         dac_clk_q  <= dac_clk_d;
         dac_data_q <= dac_data_d;
         underrun_q <= underrun_d;
      end
   end

   // Sample storage, no reset needed: occupancy is tracked by the pointers
   always_ff @(posedge aclk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= s_data;
      end
   end

   // Next-state logic
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      phase_d    = phase_q;
      period_d   = period_q;
      dac_clk_d  = dac_clk_q;
      dac_data_d = dac_data_q;
      underrun_d = underrun_q;

      empty      = (level_q == '0);
      s_ready    = (level_q != LVL_W'(FIFO_DEPTH));
      tick       = enable && (phase_q == '0);
      push       = s_valid && s_ready && !flush;
      pop        = tick && !empty && !flush;
      period_new = (clk_div == '0) ? CNT_W'(2) : CNT_W'(clk_div) + CNT_W'(1);
      half       = period_q >> 1;

      // FIFO pointers and occupancy; flush discards any same-cycle push/pop
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         level_d = level_q + LVL_W'(push) - LVL_W'(pop);
      end

      // Clear first so a same-cycle underrun set wins
      if (underrun_clr) underrun_d = 1'b0;

      // Pacing: tick at phase 0, dac_clk rise at phase H
      if (!enable) begin
         phase_d   = '0;
         dac_clk_d = 1'b0;
      end else if (phase_q == '0) begin
         period_d  = period_new;
         phase_d   = CNT_W'(1);
         dac_clk_d = 1'b0;
         if (pop)   dac_data_d = mem_q[rd_ptr_q];
         if (empty) underrun_d = 1'b1;
      end else begin
         phase_d = (phase_q == period_q - CNT_W'(1)) ? '0 : phase_q + CNT_W'(1);
         if (phase_q == half) dac_clk_d = 1'b1;
      end
   end

   assign dac_clk    = dac_clk_q;
   assign dac_data   = dac_data_q;
   assign fifo_level = level_q;
   assign underrun   = underrun_q;
   assign busy       = enable || !empty;

endmodule
